// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID register
// One outstanding imem request; squashed responses are absorbed in DROP.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_id_write,
  input  logic        if_lw,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fe_valid,
  output logic [31:0] fe_pc,
  output logic [31:0] fe_pc_4,
  output logic [31:0] fe_inst,
  output logic        if_flush
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  logic        w_stall;
  logic        w_accept;
  logic [31:0] w_target;
  logic [31:0] w_pc_4;

  assign w_stall  = ~if_id_write | if_lw;
  assign w_target = redirect_target & ~32'h3;
  assign w_pc_4   = r_pc + 32'd4;

  // Outputs are masked while reset is held so nothing leaks during the reset cycle.
  assign imem_req  = (r_state == S_FETCH) & ~reset;
  assign imem_addr = r_pc;
  assign fe_valid  = (r_state == S_HOLD) & ~reset;
  assign fe_pc     = r_pc;
  assign fe_pc_4   = w_pc_4;
  assign fe_inst   = fe_valid ? r_inst : NOP_INST;
  assign if_flush  = redirect;
  assign w_accept  = fe_valid & ~w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC_ALIGNED;
      r_inst  <= NOP_INST;
    end else begin
      case (r_state)
        S_FETCH: begin
          // A grant coinciding with a redirect leaves a stale request in flight.
          if (redirect) begin
            r_pc    <= w_target;
            r_state <= imem_gnt ? S_DROP : S_FETCH;
          end else if (imem_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_state <= imem_rvalid ? S_FETCH : S_DROP;
          end else if (imem_rvalid) begin
            r_inst  <= imem_rdata;
            r_state <= S_HOLD;
          end
        end
        S_DROP: begin
          if (redirect) begin
            r_pc <= w_target;
            if (imem_rvalid) begin
              r_state <= S_FETCH;
            end
          end else if (imem_rvalid) begin
            r_state <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (w_accept) begin
            r_pc    <= w_pc_4;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed table, wrap sequence and randomized model check
// The random phase models the fetch stream abstractly: expected PC plus freshness of the last grant.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset, if_id_write, if_lw, redirect;
  logic [31:0] redirect_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        fe_valid, if_flush;
  logic [31:0] fe_pc, fe_pc_4, fe_inst;

  logic        reset2, if_id_write2, if_lw2, redirect2;
  logic [31:0] redirect_target2;
  logic        imem_req2, imem_gnt2, imem_rvalid2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        fe_valid2, if_flush2;
  logic [31:0] fe_pc2, fe_pc_4_2, fe_inst2;

  int total = 0;
  int bad   = 0;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .if_id_write(if_id_write), .if_lw(if_lw),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_pc_4(fe_pc_4), .fe_inst(fe_inst),
    .if_flush(if_flush)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0000)) dut_wrap (
    .clk(clk), .reset(reset2), .if_id_write(if_id_write2), .if_lw(if_lw2),
    .redirect(redirect2), .redirect_target(redirect_target2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .fe_valid(fe_valid2), .fe_pc(fe_pc2), .fe_pc_4(fe_pc_4_2), .fe_inst(fe_inst2),
    .if_flush(if_flush2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, gnt, rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] tgt;
    logic        idw, lw;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
    logic        e_flush;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(input logic rst, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic redir,
                              input logic [31:0] tgt, input logic idw, input logic lw,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_inst, input logic e_flush);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.redir = redir; v.tgt = tgt;
    v.idw = idw; v.lw = lw; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_flush = e_flush;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [31:0] exp_pc, last_data, pend_data;
  logic        clean, pend, stall;
  int          cnt, accepts;

  initial begin
    // rst gnt rv rdata redir tgt idw lw | req addr valid pc inst flush
    tbl[0]  = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b0,32'h0,  32'h0,1'b0);
    tbl[1]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'h0,  1'b0,32'h0,  32'h0,1'b0);
    tbl[2]  = mk(1'b0,1'b0,1'b1,32'h11111111,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
    tbl[3]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b1,32'h0,  32'h11111111,1'b0);
    tbl[4]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'h4,  1'b0,32'h0,  32'h0,1'b0);
    tbl[5]  = mk(1'b0,1'b0,1'b1,32'h22222222,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
    tbl[6]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b1,32'h4,  32'h22222222,1'b0);
    tbl[7]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'h8,  1'b0,32'h0,  32'h0,1'b0);
    tbl[8]  = mk(1'b0,1'b0,1'b1,32'h33333333,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
    tbl[9]  = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b1,32'h8,  32'h33333333,1'b0);
    tbl[10] = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'hC,  1'b0,32'h0,  32'h0,1'b0);
    tbl[11] = mk(1'b0,1'b0,1'b1,32'h44444444,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
    tbl[12] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b1,32'hC,  32'h44444444,1'b0);
    tbl[13] = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'h10, 1'b0,32'h0,  32'h0,1'b0);
    tbl[14] = mk(1'b0,1'b0,1'b1,32'h55555555,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
    for (int i = 15; i < 19; i++)
      tbl[i] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b1, 1'b0,32'h0,1'b1,32'h10,32'h55555555,1'b0);
    tbl[19] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0, 1'b0,32'h0,  1'b1,32'h10, 32'h55555555,1'b0);
    tbl[20] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b1,32'h10, 32'h55555555,1'b0);
    tbl[21] = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'h14, 1'b0,32'h0,  32'h0,1'b0);
    tbl[22] = mk(1'b0,1'b0,1'b0,32'h0,1'b1,32'h200,1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0,  32'h0,1'b1);
    tbl[23] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b0,32'h0,  32'h0,1'b0);
    tbl[24] = mk(1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
    tbl[25] = mk(1'b0,1'b1,1'b0,32'h0,1'b1,32'h103,1'b1,1'b0, 1'b1,32'h200,1'b0,32'h0, 32'h0,1'b1);
    tbl[26] = mk(1'b0,1'b0,1'b1,32'hBADBAD00,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
    tbl[27] = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'h100,1'b0,32'h0,  32'h0,1'b0);
    tbl[28] = mk(1'b0,1'b0,1'b1,32'h66666666,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,32'h0,1'b0);
    tbl[29] = mk(1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0,1'b1,1'b1, 1'b0,32'h0,1'b1,32'h100,32'h66666666,1'b0);
    tbl[30] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b1,32'h100,32'h66666666,1'b0);
    tbl[31] = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'h104,1'b0,32'h0,  32'h0,1'b0);
    tbl[32] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b0,32'h0,  1'b0,32'h0,  32'h0,1'b0);
    tbl[33] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0, 1'b1,32'h0,  1'b0,32'h0,  32'h0,1'b0);

    reset = 1'b1; if_id_write = 1'b1; if_lw = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    reset2 = 1'b1; if_id_write2 = 1'b1; if_lw2 = 1'b0; redirect2 = 1'b0; redirect_target2 = '0;
    imem_gnt2 = 1'b0; imem_rvalid2 = 1'b0; imem_rdata2 = '0;

    // Wrap sequence on the instance reset to 0xFFFF_FFFC.
    @(posedge clk);
    @(negedge clk); reset2 = 1'b0; imem_gnt2 = 1'b1; #1;
    chk("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
    @(negedge clk); imem_gnt2 = 1'b0; imem_rvalid2 = 1'b1; imem_rdata2 = 32'hCAFE_0001;
    @(negedge clk); imem_rvalid2 = 1'b0; #1;
    chk("wrap_valid", 32'(fe_valid2), 32'h1);
    chk("wrap_pc", fe_pc2, 32'hFFFF_FFFC);
    chk("wrap_pc_4", fe_pc_4_2, 32'h0);
    @(negedge clk); #1;
    chk("wrap_next_req", 32'(imem_req2), 32'h1);
    chk("wrap_next_addr", imem_addr2, 32'h0);

    // Directed table on the main instance.
    @(negedge clk);
    for (int i = 0; i < 34; i++) begin
      reset = tbl[i].rst; imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv;
      imem_rdata = tbl[i].rdata; redirect = tbl[i].redir; redirect_target = tbl[i].tgt;
      if_id_write = tbl[i].idw; if_lw = tbl[i].lw;
      #1;
      chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d_valid", i), 32'(fe_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d_inst", i), fe_inst, tbl[i].e_inst);
      chk($sformatf("row%0d_flush", i), 32'(if_flush), 32'(tbl[i].e_flush));
      if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        chk($sformatf("row%0d_pc", i), fe_pc, tbl[i].e_pc);
        chk($sformatf("row%0d_pc_4", i), fe_pc_4, tbl[i].e_pc + 32'd4);
      end
      @(negedge clk);
    end

    // Randomized run against the abstract fetch-stream model.
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_pc = 32'h0; clean = 1'b0; pend = 1'b0; cnt = 0; accepts = 0;
    last_data = '0; pend_data = '0;
    for (int c = 0; c < 3000; c++) begin
      reset = 1'b0;
      imem_gnt = imem_req && ($urandom_range(0, 9) < 7);
      if (pend && cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = pend_data;
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
      redirect = ($urandom_range(0, 11) == 0);
      redirect_target = $urandom;
      if_lw = ($urandom_range(0, 5) == 0);
      if_id_write = ($urandom_range(0, 5) != 0);
      #1;
      chk("rnd_flush", 32'(if_flush), 32'(redirect));
      if (imem_req) begin
        chk("rnd_addr", imem_addr, exp_pc);
        chk("rnd_req_while_pending", 32'(pend), 32'h0);
      end
      if (fe_valid) begin
        chk("rnd_pc", fe_pc, exp_pc);
        chk("rnd_pc_4", fe_pc_4, exp_pc + 32'd4);
        chk("rnd_inst", fe_inst, last_data);
        chk("rnd_fresh", 32'(clean), 32'h1);
      end else begin
        chk("rnd_nop", fe_inst, 32'h0);
      end
      stall = !if_id_write || if_lw;
      if (imem_rvalid) pend = 1'b0;
      else if (pend) cnt--;
      if (redirect) begin
        exp_pc = redirect_target & ~32'h3;
        clean = 1'b0;
      end else if (fe_valid && !stall) begin
        exp_pc = exp_pc + 32'd4;
        clean = 1'b0;
        accepts++;
      end
      if (imem_req && imem_gnt) begin
        pend = 1'b1;
        cnt = $urandom_range(0, 2);
        pend_data = $urandom;
        if (!redirect) begin
          clean = 1'b1;
          last_data = pend_data;
        end
      end
      @(negedge clk);
    end
    total++;
    if (accepts < 50) begin
      bad++;
      $display("FAIL rnd_progress: got %0d accepts want >= 50", accepts);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
